ripple_adder: RTL and testbench
===============================

// Module: ripple_adder
// PURPOSE
//   Unsigned/two's-complement WIDTH-bit adder built as an explicit chain of
//   1-bit full adders (carry ripples LSB->MSB), with a registered result stage.
//   General-purpose arithmetic leaf used in datapaths that need a simple adder
//   with carry-out and a one-cycle, valid-qualified result.
// PARAMETERS
//   WIDTH   4   operand and sum width in bits (>=1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      a/b/cin are valid this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0 (tie 0 for plain a+b)
//   sum        out  WIDTH  registered (a+b+cin) mod 2^WIDTH
//   cout       out  1      registered carry out of bit WIDTH-1
//   overflow   out  1      registered signed overflow = carry into MSB ^ cout
//   out_valid  out  1      sum/cout/overflow hold a fresh result
// BEHAVIOUR
//   - Combinational core: WIDTH full-adder cells, s[i]=a[i]^b[i]^c[i],
//     c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]), c[0]=cin. No '+' operator in core.
//   - Result registered on rising clk when in_valid=1; latency exactly 1 cycle.
//   - out_valid <= in_valid every cycle (1-cycle pulse per accepted operand set).
//   - in_valid=0: sum/cout/overflow hold previous values; out_valid goes 0.
//   - rst=1 (async, any time): sum=0, cout=0, overflow=0, out_valid=0
//     immediately; held while rst=1. First capture on first clk edge with
//     rst=0 and in_valid=1. Operand presented in the reset-release cycle is
//     accepted normally if in_valid=1.
//   - Back-to-back in_valid: one result per cycle, no stalls, no backpressure.
//   - Wrap-around: result is modulo 2^WIDTH; the lost MSB appears on cout.
//   - {cout,sum} == a + b + cin (unsigned, WIDTH+1 bits) for all inputs.
//   - overflow meaningful for signed interpretation; ignored for unsigned use.
//   - No X propagation from idle inputs: outputs only change on accepted data.
// TESTING
//   1. rst pulse mid-run -> sum=0000,cout=0,overflow=0,out_valid=0 at once.
//   2. a=0000,b=0000,cin=0 -> next cycle sum=0000,cout=0,out_valid=1.
//   3. a=0001,b=0110,cin=0 -> sum=0111,cout=0,overflow=0.
//   4. a=1000,b=1001,cin=0 -> sum=0001,cout=1,overflow=1.
//   5. a=1111,b=1111,cin=0 -> sum=1110,cout=1,overflow=0; cin=1 -> sum=1111,cout=1.
//   6. in_valid=0 after test 5 -> sum/cout hold, out_valid=0; random back-to-back
//      vectors vs {cout,sum}==a+b+cin, plus WIDTH=1 and WIDTH=16 builds.

Source files
------------

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - WIDTH-bit ripple-carry adder with a registered, valid-qualified result
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // One full-adder cell per bit; the carry ripples LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Idle cycles leave the previous result in place.
      if (in_valid) begin
        sum      <= s;
        cout     <= c[WIDTH];
        overflow <= c[WIDTH-1] ^ c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ripple_adder.sv
// tb/tb_ripple_adder.sv - directed and random checks of ripple_adder at WIDTH 4, 1 and 16
module tb_ripple_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        cin;
  logic [3:0]  a4, b4, sum4;
  logic [0:0]  a1, b1, sum1;
  logic [15:0] a16, b16, sum16;
  logic        cout4, ov4, ov_valid4;
  logic        cout1, ov1, ov_valid1;
  logic        cout16, ov16, ov_valid16;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [16:0] exp16;
  logic [4:0]  exp4;
  logic [1:0]  exp1;

  always #5 clk = ~clk;

  ripple_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
    .sum(sum4), .cout(cout4), .overflow(ov4), .out_valid(ov_valid4)
  );

  ripple_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .sum(sum1), .cout(cout1), .overflow(ov1), .out_valid(ov_valid1)
  );

  ripple_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin),
    .sum(sum16), .cout(cout16), .overflow(ov16), .out_valid(ov_valid16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] x4, input logic [3:0] y4,
                      input logic x1, input logic y1,
                      input logic [15:0] x16, input logic [15:0] y16, input logic ci);
    @(negedge clk);
    in_valid = v;
    a4 = x4; b4 = y4; a1 = x1; b1 = y1; a16 = x16; b16 = y16; cin = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cin = 1'b0;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {sum4, cout4, ov4, ov_valid4}, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("zero_sum", {sum4, cout4, ov4, ov_valid4}, {4'h0, 1'b0, 1'b0, 1'b1});

    step(1'b1, 4'h1, 4'h6, 1'b1, 1'b0, 16'hffff, 16'h0001, 1'b0);
    chk("1p6", {sum4, cout4, ov4}, {4'h7, 1'b0, 1'b0});
    chk("w1_1p0", {sum1, cout1, ov1}, {1'b1, 1'b0, 1'b0});
    chk("w16_wrap", {sum16, cout16, ov16}, {16'h0000, 1'b1, 1'b0});

    step(1'b1, 4'h8, 4'h9, 1'b1, 1'b1, 16'h7fff, 16'h0001, 1'b0);
    chk("8p9", {sum4, cout4, ov4}, {4'h1, 1'b1, 1'b1});
    chk("w1_1p1", {sum1, cout1, ov1}, {1'b0, 1'b1, 1'b1});
    chk("w16_sovf", {sum16, cout16, ov16}, {16'h8000, 1'b0, 1'b1});

    step(1'b1, 4'h7, 4'h1, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
    chk("7p1_sovf", {sum4, cout4, ov4}, {4'h8, 1'b0, 1'b1});
    chk("w16_plain", {sum16, cout16}, {16'h5555, 1'b0});

    step(1'b1, 4'hf, 4'hf, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("fpf", {sum4, cout4, ov4, ov_valid4}, {4'he, 1'b1, 1'b0, 1'b1});

    step(1'b1, 4'hf, 4'hf, 1'b1, 1'b1, 16'hffff, 16'hffff, 1'b1);
    chk("fpf_cin", {sum4, cout4, ov4}, {4'hf, 1'b1, 1'b0});
    chk("w1_all1", {sum1, cout1}, {1'b1, 1'b1});
    chk("w16_all1", {sum16, cout16}, {16'hffff, 1'b1});

    step(1'b0, 4'h5, 4'h2, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);
    chk("idle_hold", {sum4, cout4, ov4, ov_valid4}, {4'hf, 1'b1, 1'b0, 1'b0});
    chk("idle_hold16", {sum16, ov_valid16}, {16'hffff, 1'b0});

    // Asynchronous reset between clock edges must clear outputs at once.
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", {sum4, cout4, ov4, ov_valid4, sum16, ov_valid1}, 32'h0);

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a4 = 4'h3; b4 = 4'h4; cin = 1'b0;
    @(posedge clk);
    #1;
    chk("release_accept", {sum4, cout4, ov_valid4}, {4'h7, 1'b0, 1'b1});

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a4 = 4'($urandom); b4 = 4'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom);
      exp4  = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
      exp1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
      exp16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin};
      @(posedge clk);
      #1;
      chk("rand_w4", {cout4, sum4, ov_valid4}, {exp4, 1'b1});
      chk("rand_w1", {cout1, sum1, ov_valid1}, {exp1, 1'b1});
      chk("rand_w16", {cout16, sum16, ov_valid16}, {exp16, 1'b1});
    end

    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("final_idle", {cout16, sum16, ov_valid16}, {exp16, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
